// File: rtl/ibex_pkg.sv
// Shared fetch front-end types: aligner state encoding and the RVC length test.
// The compressed helper is only referenced when IBEX_ALIGNER_RVC_EN is defined.
package ibex_pkg;

  typedef enum logic [1:0] {
    ALIGNED,
    HALF,
    BR_SKIP
  } aligner_state_e;

  localparam logic [31:0] ALIGNER_PC_RESET = 32'h0;

  function automatic logic is_compressed(input logic [1:0] opcode_lsbs);
    return opcode_lsbs != 2'b11;
  endfunction

endpackage

// File: rtl/ibex_instr_aligner.sv
// Splits word-aligned fetch data into complete 16/32-bit instructions with zero latency.
// Define IBEX_ALIGNER_RVC_EN for compressed support; otherwise every word is one instruction.
module ibex_instr_aligner
  import ibex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_step;
  logic [31:0] out_instr;
  logic        out_valid;
  logic        out_err;
  logic        fetch_ready;
  logic        handshake;

  // Halfword granularity means bit 0 of a target never matters.
  logic unused_branch_lsb;
  assign unused_branch_lsb = branch_addr_i[0];

`ifdef IBEX_ALIGNER_RVC_EN

  aligner_state_e state_q, state_d;
  logic [15:0]    held_q, held_d;
  logic           held_err_q, held_err_d;

  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    held_err_d  = held_err_q;
    out_valid   = 1'b0;
    fetch_ready = 1'b0;
    out_instr   = fetch_rdata_i;
    out_err     = fetch_err_i;

    case (state_q)
      ALIGNED: begin
        out_valid   = fetch_valid_i;
        fetch_ready = out_ready_i;
        if (is_compressed(fetch_rdata_i[1:0])) begin
          out_instr = {16'h0, fetch_rdata_i[15:0]};
          if (fetch_valid_i && out_ready_i) begin
            held_d     = fetch_rdata_i[31:16];
            held_err_d = fetch_err_i;
            state_d    = HALF;
          end
        end
      end
      HALF: begin
        if (is_compressed(held_q[1:0])) begin
          // The held half is a whole instruction, so the fetch word must wait.
          out_valid = 1'b1;
          out_instr = {16'h0, held_q};
          out_err   = held_err_q;
          if (out_ready_i) begin
            state_d = ALIGNED;
          end
        end else begin
          out_valid   = fetch_valid_i;
          fetch_ready = out_ready_i;
          out_instr   = {fetch_rdata_i[15:0], held_q};
          out_err     = held_err_q | fetch_err_i;
          if (fetch_valid_i && out_ready_i) begin
            held_d     = fetch_rdata_i[31:16];
            held_err_d = fetch_err_i;
          end
        end
      end
      BR_SKIP: begin
        fetch_ready = 1'b1;
        if (fetch_valid_i) begin
          held_d     = fetch_rdata_i[31:16];
          held_err_d = fetch_err_i;
          state_d    = HALF;
        end
      end
      default: state_d = ALIGNED;
    endcase

    if (branch_i) begin
      out_valid   = 1'b0;
      fetch_ready = 1'b0;
      held_d      = 16'h0;
      held_err_d  = 1'b0;
      state_d     = branch_addr_i[1] ? BR_SKIP : ALIGNED;
    end
  end

  assign pc_step = is_compressed(out_instr[1:0]) ? 32'd2 : 32'd4;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ALIGNED;
      held_q     <= 16'h0;
      held_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      held_err_q <= held_err_d;
    end
  end

`else

  // Without RVC a halfword-aligned target cannot be fetched, so the next
  // instruction delivered after such a branch is marked as faulting.
  logic misalign_q, misalign_d;

  always_comb begin
    out_valid   = fetch_valid_i & ~branch_i;
    fetch_ready = out_ready_i & ~branch_i;
    out_instr   = fetch_rdata_i;
    out_err     = fetch_err_i | misalign_q;
    misalign_d  = misalign_q;
    if (out_valid && out_ready_i) begin
      misalign_d = 1'b0;
    end
    if (branch_i) begin
      misalign_d = branch_addr_i[1];
    end
  end

  assign pc_step = 32'd4;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

`endif

  assign handshake = out_valid & out_ready_i;

  always_comb begin
    pc_d = pc_q;
    if (handshake) begin
      pc_d = pc_q + pc_step;
    end
    if (branch_i) begin
      pc_d = {branch_addr_i[31:1], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= ALIGNER_PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Handshake-related outputs are forced quiet while reset is held.
  assign out_valid_o   = out_valid & rst_ni;
  assign fetch_ready_o = fetch_ready & rst_ni;
  assign out_err_o     = out_err & rst_ni;
  assign out_instr_o   = out_instr;
  assign out_addr_o    = pc_q;

endmodule

// File: tb/tb_ibex_instr_aligner.sv
// Self-checking bench for ibex_instr_aligner: directed literal checks plus a
// randomized run compared every cycle against a halfword-stream reference model.
module tb_ibex_instr_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_rdata;
  logic        fetch_err;
  logic        branch;
  logic [31:0] branch_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [15:0] hw;
    logic        err;
  } halfT;

  // Reference model state: halfwords received but not yet issued.
  halfT        mQ[$];
  logic        mSkip;
  logic        mMis;
  logic [31:0] mPc;

  ibex_instr_aligner dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .fetch_valid_i (fetch_valid),
    .fetch_ready_o (fetch_ready),
    .fetch_rdata_i (fetch_rdata),
    .fetch_err_i   (fetch_err),
    .branch_i      (branch),
    .branch_addr_i (branch_addr),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_instr_o   (out_instr),
    .out_addr_o    (out_addr),
    .out_err_o     (out_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic fv, input logic [31:0] data, input logic ferr,
                               input logic ordy, input logic br, input logic [31:0] baddr);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    fetch_valid = fv;
    fetch_rdata = data;
    fetch_err   = ferr;
    out_ready   = ordy;
    branch      = br;
    branch_addr = baddr;
    #2;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    fetch_valid = 1'b1;
    fetch_rdata = 32'h00A00093;
    fetch_err   = 1'b1;
    out_ready   = 1'b1;
    branch      = 1'b0;
    branch_addr = 32'h0;
    #2;
    checkOutput("rst_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_fready", 32'(fetch_ready), 32'h0);
    checkOutput("rst_err", 32'(out_err), 32'h0);
    checkOutput("rst_addr", out_addr, 32'h0);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    fetch_valid = 1'b0;
    fetch_err   = 1'b0;
  endtask

  // Reference model: sampled mid-cycle, then advanced as the coming edge will.
  always @(negedge clk) begin
    halfT        avail[$];
    int          used;
    logic        expValid;
    logic        expReady;
    logic        expErr;
    logic [31:0] expInstr;
    if (!rst_n) begin
      checkOutput("m_rst_valid", 32'(out_valid), 32'h0);
      checkOutput("m_rst_fready", 32'(fetch_ready), 32'h0);
      checkOutput("m_rst_err", 32'(out_err), 32'h0);
      mQ.delete();
      mSkip = 1'b0;
      mMis  = 1'b0;
      mPc   = 32'h0;
    end else if (branch) begin
      checkOutput("m_br_valid", 32'(out_valid), 32'h0);
      checkOutput("m_br_fready", 32'(fetch_ready), 32'h0);
      mQ.delete();
`ifdef IBEX_ALIGNER_RVC_EN
      mSkip = branch_addr[1];
`else
      mMis = branch_addr[1];
`endif
      mPc = {branch_addr[31:1], 1'b0};
    end else begin
`ifdef IBEX_ALIGNER_RVC_EN
      if (mSkip) begin
        checkOutput("m_skip_valid", 32'(out_valid), 32'h0);
        checkOutput("m_skip_fready", 32'(fetch_ready), 32'h1);
        if (fetch_valid) begin
          mQ.delete();
          mQ.push_back('{fetch_rdata[31:16], fetch_err});
          mSkip = 1'b0;
        end
      end else begin
        avail = mQ;
        if (fetch_valid) begin
          avail.push_back('{fetch_rdata[15:0], fetch_err});
          avail.push_back('{fetch_rdata[31:16], fetch_err});
        end
        used = 0;
        if (avail.size() >= 1 && avail[0].hw[1:0] != 2'b11) used = 1;
        else if (avail.size() >= 2) used = 2;
        expValid = (used != 0);
        expReady = (mQ.size() > 0 && mQ[0].hw[1:0] != 2'b11) ? 1'b0 : out_ready;
        checkOutput("m_valid", 32'(out_valid), 32'(expValid));
        checkOutput("m_fready", 32'(fetch_ready), 32'(expReady));
        if (expValid) begin
          expInstr = (used == 1) ? {16'h0, avail[0].hw} : {avail[1].hw, avail[0].hw};
          expErr   = (used == 1) ? avail[0].err : (avail[0].err | avail[1].err);
          checkOutput("m_instr", out_instr, expInstr);
          checkOutput("m_addr", out_addr, mPc);
          checkOutput("m_err", 32'(out_err), 32'(expErr));
          if (out_ready) begin
            mPc = mPc + 32'(2 * used);
            if (used > mQ.size()) mQ = avail;
            repeat (used) void'(mQ.pop_front());
          end
        end
      end
`else
      checkOutput("m_valid", 32'(out_valid), 32'(fetch_valid));
      checkOutput("m_fready", 32'(fetch_ready), 32'(out_ready));
      if (fetch_valid) begin
        checkOutput("m_instr", out_instr, fetch_rdata);
        checkOutput("m_addr", out_addr, mPc);
        checkOutput("m_err", 32'(out_err), 32'(fetch_err | mMis));
        if (out_ready) begin
          mPc  = mPc + 32'd4;
          mMis = 1'b0;
        end
      end
`endif
    end
  end

  initial begin
    rst_n       = 1'b0;
    fetch_valid = 1'b0;
    fetch_rdata = 32'h0;
    fetch_err   = 1'b0;
    out_ready   = 1'b0;
    branch      = 1'b0;
    branch_addr = 32'h0;
    mQ.delete();
    mSkip = 1'b0;
    mMis  = 1'b0;
    mPc   = 32'h0;

    doReset();
    applyStimulus(1'b1, 32'h00A00093, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("d_full_valid", 32'(out_valid), 32'h1);
    checkOutput("d_full_instr", out_instr, 32'h00A00093);
    checkOutput("d_full_addr", out_addr, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("d_full_nextpc", out_addr, 32'h4);

`ifdef IBEX_ALIGNER_RVC_EN
    doReset();
    applyStimulus(1'b1, 32'h00930505, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("d_c0_instr", out_instr, 32'h00000505);
    checkOutput("d_c0_addr", out_addr, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("d_half_wait_valid", 32'(out_valid), 32'h0);
    checkOutput("d_half_wait_fready", 32'(fetch_ready), 32'h1);

    doReset();
    applyStimulus(1'b1, 32'h00130505, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("d_span_c_instr", out_instr, 32'h00000505);
    applyStimulus(1'b1, 32'h12340093, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("d_span_instr", out_instr, 32'h00930013);
    checkOutput("d_span_addr", out_addr, 32'h2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("d_held_valid", 32'(out_valid), 32'h1);
    checkOutput("d_held_instr", out_instr, 32'h00001234);
    checkOutput("d_held_addr", out_addr, 32'h6);
    checkOutput("d_held_fready", 32'(fetch_ready), 32'h0);

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h00000102);
    checkOutput("d_br_valid", 32'(out_valid), 32'h0);
    checkOutput("d_br_fready", 32'(fetch_ready), 32'h0);
    applyStimulus(1'b1, 32'h4501ABCD, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("d_skip_valid", 32'(out_valid), 32'h0);
    checkOutput("d_skip_fready", 32'(fetch_ready), 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("d_skip_instr", out_instr, 32'h00004501);
    checkOutput("d_skip_addr", out_addr, 32'h00000102);

    doReset();
    applyStimulus(1'b1, 32'h00130505, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h12340093, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("d_stall_valid", 32'(out_valid), 32'h1);
      checkOutput("d_stall_instr", out_instr, 32'h00930013);
      checkOutput("d_stall_addr", out_addr, 32'h2);
      checkOutput("d_stall_err", 32'(out_err), 32'h1);
    end
    applyStimulus(1'b1, 32'h12340093, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("d_held_err", 32'(out_err), 32'h1);
    checkOutput("d_held_err_addr", out_addr, 32'h6);
`else
    applyStimulus(1'b1, 32'h00130505, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("d_word_instr", out_instr, 32'h00130505);
    checkOutput("d_word_addr", out_addr, 32'h4);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h00000102);
    checkOutput("d_br_valid", 32'(out_valid), 32'h0);
    checkOutput("d_br_fready", 32'(fetch_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h4501ABCD, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("d_mis_instr", out_instr, 32'h4501ABCD);
      checkOutput("d_mis_addr", out_addr, 32'h00000102);
      checkOutput("d_mis_err", 32'(out_err), 32'h1);
    end
    applyStimulus(1'b1, 32'h4501ABCD, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h11111111, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("d_ferr_err", 32'(out_err), 32'h1);
    checkOutput("d_ferr_addr", out_addr, 32'h00000106);
    applyStimulus(1'b1, 32'h22222222, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("d_clr_err", 32'(out_err), 32'h0);
    checkOutput("d_clr_addr", out_addr, 32'h0000010A);
`endif

    // Random traffic; the reference model checks every cycle.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      rst_n       = ($urandom_range(0, 299) != 0);
      fetch_valid = ($urandom_range(0, 3) != 0);
      fetch_rdata = $urandom();
      fetch_err   = ($urandom_range(0, 15) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      branch      = ($urandom_range(0, 15) == 0);
      branch_addr = $urandom();
    end

    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    fetch_valid = 1'b0;
    branch      = 1'b0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
